// File: rtl/adder_seq_ctrl_if.sv
// adder_seq_ctrl_if: operand request and result handshake bundle for adder_seq_ctrl
interface adder_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             sub_i;
  logic             carry_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             overflow_o;
  modport master (
    output valid_i, a_i, b_i, sub_i, carry_i, ready_i,
    input  ready_o, valid_o, sum_o, carry_o, overflow_o
  );
  modport slave (
    input  valid_i, a_i, b_i, sub_i, carry_i, ready_i,
    output ready_o, valid_o, sum_o, carry_o, overflow_o
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: nibble-serial add/subtract sequencer around one 4-bit ripple slice
module fulladder4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] c;
  assign c[0] = c_i;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign c_o = c[4];
endmodule

module adder_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  adder_seq_ctrl_if.slave  bus
);
  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, sum_q, sum_d;
  logic             cy_q, cy_d, carry_q, carry_d, ovf_q, ovf_d, valid_q, valid_d;
  logic [3:0]       fa_s;
  logic             fa_co, last;
  fulladder4 u_fa (
    .a_i (op_a_q[{cnt_q, 2'b00} +: 4]),
    .b_i (op_b_q[{cnt_q, 2'b00} +: 4]),
    .c_i (cy_q),
    .s_o (fa_s),
    .c_o (fa_co)
  );
  assign last         = cnt_q == CW'(N - 1);
  assign bus.ready_o    = state_q == IDLE;
  assign bus.valid_o    = valid_q;
  assign bus.sum_o      = sum_q;
  assign bus.carry_o    = carry_q;
  assign bus.overflow_o = ovf_q;
  // next-state: latch operands on accept, one nibble per CALC cycle, hold result in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    cy_d    = cy_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (bus.valid_i) begin
        op_a_d  = bus.a_i;
        op_b_d  = bus.sub_i ? ~bus.b_i : bus.b_i;
        cy_d    = bus.sub_i | bus.carry_i;
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        sum_d[{cnt_q, 2'b00} +: 4] = fa_s;
        cy_d    = fa_co;
        cnt_d   = last ? cnt_q : cnt_q + CW'(1);
        state_d = last ? DONE : CALC;
        valid_d = last;
        carry_d = last ? fa_co : carry_q;
        ovf_d   = last ? (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (fa_s[3] != op_a_q[WIDTH-1]) : ovf_q;
      end
      DONE: if (bus.ready_i) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      cy_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cy_q    <= cy_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: doc/adder_seq_ctrl.md
# adder_seq_ctrl

Multi-cycle sequencer that performs WIDTH-bit add/subtract by time-sharing one 4-bit ripple adder slice (`fulladder4`), one nibble per clock, least significant nibble first. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It is the area-minimal arithmetic path for the CPU's multi-cycle execute option.

## Interface
- WIDTH, 32: operand/result width in bits. Must be a multiple of 4 and at least 8. N = WIDTH/4 nibble steps.
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- valid_i  in  1  operand request valid.
- ready_o  out  1  block can accept a request. High exactly in IDLE.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- sub_i  in  1  1 = A − B, 0 = A + B.
- carry_i  in  1  carry-in for addition. Ignored when sub_i=1.
- valid_o  out  1  result valid. Held until consumed.
- ready_i  in  1  consumer accepts result.
- sum_o  out  WIDTH  result.
- carry_o  out  1  carry out of the MSB. For subtraction, 1 = no borrow.
- overflow_o  out  1  two's-complement signed overflow.

## Operation
- Exactly one `fulladder4` instance. Its a/b/carry inputs are driven from latched operand registers, selected by the nibble counter.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i && ready_o: latch opA=a_i and opB = sub_i ? ~b_i : b_i.
  - Load carry register with sub_i ? 1 : carry_i.
  - Clear the nibble counter. Go to CALC.
- CALC:
  - Each cycle the adder sees opA[4k+3:4k], opB[4k+3:4k] and the carry register, where k is the counter value.
  - Its sum nibble is written into sum register bits [4k+3:4k]. Its carry_o is written into the carry register. k increments.
  - When k = N−1 is processed, go to DONE. At that edge also register carry_o and overflow_o.
  - overflow = (opA[MSB] == opB[MSB]) && (sum[MSB] != opA[MSB]), evaluated on the final sum.
- DONE:
  - valid_o=1. sum_o, carry_o and overflow_o are held stable.
  - On ready_i: go to IDLE and deassert valid_o.
- Requests are not accepted in CALC or DONE, because ready_o=0. valid_i is ignored there and operand inputs may change freely.
- The counter is ceil(log2 N) bits wide. It never wraps past N−1; it is reloaded with 0 on acceptance.
- Registers not written during an operation (sum_o nibbles not yet computed) hold their previous values. sum_o is only meaningful while valid_o=1.

## Timing
- Reset (rst_ni low, asynchronous):
  - State is IDLE and counter=0.
  - valid_o=0, sum_o=0, carry_o=0, overflow_o=0, carry register=0.
  - ready_o=1, since it decodes from state.
- Reset asserted mid-CALC or mid-DONE aborts the operation immediately. No valid_o pulse is produced afterwards.
- Latency:
  - Request accepted at edge E0.
  - Nibble k is computed in the cycle after E0+k and written at edge E0+k+1.
  - valid_o rises after edge E0+N (8 cycles for WIDTH=32).
- Result handshake at edge Ed (valid_o && ready_i): ready_o rises after Ed. The earliest next acceptance is edge Ed+1.
- Throughput: with ready_i tied high, one operation per N+2 cycles.
- ready_i is ignored outside DONE.
- All outputs except ready_o come directly from flops.

## Test plan
- Add: a=0x0000_0001, b=0xFFFF_FFFF, sub=0, carry_i=0, ready_i=1. Require sum_o=0x0000_0000, carry_o=1, overflow_o=0, and valid_o exactly 8 cycles after acceptance, lasting 1 cycle.
- Subtract: a=5, b=7, sub=1, carry_i=1 (ignored). Require sum_o=0xFFFF_FFFE, carry_o=0 (borrow), overflow_o=0.
- Signed overflow: a=0x7FFF_FFFF, b=1, add. Require sum_o=0x8000_0000, overflow_o=1, carry_o=0.
- Carry-in propagation: a=0xFFFF_FFFF, b=0, carry_i=1. Require sum_o=0, carry_o=1.
- Backpressure and ignored requests:
  - Toggle valid_i and operands during CALC. Require ready_o=0 and the result unaffected.
  - Hold ready_i=0 for 5 cycles in DONE. Require valid_o, sum_o and flags stable.
  - Release ready_i. Require ready_o=1 on the next cycle and a back-to-back second operation to give the correct result.
- Reset mid-operation: assert rst_ni low asynchronously after nibble 3 of 0x1234_5678+0x1111_1111. Require valid_o=0, ready_o=1 and all outputs 0 immediately. After release, 0x0000_000F+1 gives 0x0000_0010.
